// File: rtl/urng_pair_collector.sv
// -----------------------------------------------------------------------------
// urng_pair_collector
//
// Purpose:
//   Receiving end of a free-running uniform random number stream. Consecutive
//   words are grouped into (u0, u1) pairs for a Box-Muller stage. A u0 of zero
//   is rejected because ln(0) is undefined. Completed pairs are buffered in a
//   small show-ahead FIFO and presented on a valid/ready interface. The source
//   cannot be stalled, so a pair that finds the FIFO full is dropped and
//   accounted for in a saturating counter plus a sticky overflow flag.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous active-high reset
//   in_data      uniform word from the generator
//   in_valid     in_data valid this cycle (no backpressure)
//   out_u0       head pair, first word (never 0 while out_valid=1)
//   out_u1       head pair, second word
//   out_valid    FIFO non-empty
//   out_ready    consumer accepts the head pair
//   fill_level   number of pairs currently stored
//   drop_count   words discarded due to a full FIFO (saturating)
//   overflow     sticky: at least one drop since reset/clear
//   clear_stats  clears drop_count and overflow
// -----------------------------------------------------------------------------
module urng_pair_collector #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic [DATA_W-1:0]        out_u0,
    output logic [DATA_W-1:0]        out_u1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow,
    input  logic                     clear_stats
);

    localparam int                AW        = $clog2(DEPTH);
    localparam logic [AW:0]       FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0]       PTR_ONE   = (AW+1)'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_TWO   = CNT_W'(2);

    typedef enum logic [0:0] {
        WAIT_U0 = 1'b0,
        WAIT_U1 = 1'b1
    } state_t;

    // A dropped pair represents two lost words; the counter sticks at its maximum.
    function automatic logic [CNT_W-1:0] sat_add_two(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value >= (CNT_MAX - CNT_TWO)) begin
            result = CNT_MAX;
        end else begin
            result = value + CNT_TWO;
        end
        return result;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_u0_hold;
    logic               w_latch_u0;
    logic               w_push_req;

    logic [DATA_W-1:0]  r_mem_u0 [DEPTH];
    logic [DATA_W-1:0]  r_mem_u1 [DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [AW:0]        w_fill;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    logic [CNT_W-1:0]   r_drop_count;
    logic               r_overflow;

    // Pairing FSM next-state logic: zero u0 words are skipped, u1 is taken as-is.
    always_comb begin
        w_state_nxt = r_state;
        w_latch_u0  = 1'b0;
        w_push_req  = 1'b0;
        case (r_state)
            WAIT_U0: begin
                if (in_valid && (in_data != {DATA_W{1'b0}})) begin
                    w_latch_u0  = 1'b1;
                    w_state_nxt = WAIT_U1;
                end else begin
                    w_state_nxt = WAIT_U0;
                end
            end
            WAIT_U1: begin
                if (in_valid) begin
                    w_push_req  = 1'b1;
                    w_state_nxt = WAIT_U0;
                end else begin
                    w_state_nxt = WAIT_U1;
                end
            end
            default: begin
                w_state_nxt = WAIT_U0;
            end
        endcase
    end

    // FIFO occupancy and push/pop qualification; the extra pointer bit separates full from empty.
    always_comb begin
        w_fill  = r_wr_ptr - r_rd_ptr;
        w_empty = (r_wr_ptr == r_rd_ptr);
        w_full  = (w_fill == FULL_CNT);
        w_pop   = (!w_empty) && out_ready;
        // A full FIFO still accepts a pair when the head leaves in the same cycle.
        w_push  = w_push_req && ((!w_full) || w_pop);
        w_drop  = w_push_req && (!w_push);
    end

    // Pairing FSM state register and held first word.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= WAIT_U0;
            r_u0_hold <= {DATA_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_latch_u0) begin
                r_u0_hold <= in_data;
            end else begin
                r_u0_hold <= r_u0_hold;
            end
        end
    end

    // Pair storage; when full with a concurrent pop the write lands in the slot being vacated.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_u0[i] <= {DATA_W{1'b0}};
                r_mem_u1[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_mem_u0[r_wr_ptr[AW-1:0]] <= r_u0_hold;
                r_mem_u1[r_wr_ptr[AW-1:0]] <= in_data;
            end
        end
    end

    // FIFO read and write pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

    // Drop statistics; a drop in the same cycle as a clear takes precedence.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_drop_count <= {CNT_W{1'b0}};
            r_overflow   <= 1'b0;
        end else if (w_drop) begin
            if (clear_stats) begin
                r_drop_count <= CNT_TWO;
            end else begin
                r_drop_count <= sat_add_two(r_drop_count);
            end
            r_overflow <= 1'b1;
        end else if (clear_stats) begin
            r_drop_count <= {CNT_W{1'b0}};
            r_overflow   <= 1'b0;
        end else begin
            r_drop_count <= r_drop_count;
            r_overflow   <= r_overflow;
        end
    end

    // Outputs come straight from registered storage and pointers.
    always_comb begin
        out_u0     = r_mem_u0[r_rd_ptr[AW-1:0]];
        out_u1     = r_mem_u1[r_rd_ptr[AW-1:0]];
        out_valid  = !w_empty;
        fill_level = w_fill;
        drop_count = r_drop_count;
        overflow   = r_overflow;
    end

endmodule

// File: tb/tb_urng_pair_collector.sv
// -----------------------------------------------------------------------------
// tb_urng_pair_collector
//
// Self-checking bench for urng_pair_collector. The driver applies one cycle of
// stimulus per call and advances a queue-based reference model; accepted pairs
// are pushed to a scoreboard queue. A negedge monitor compares status outputs
// with the model every cycle and pops/compares a pair whenever the DUT hands
// one over (out_valid & out_ready).
// -----------------------------------------------------------------------------
module tb_urng_pair_collector;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clock;
    logic              reset;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_u0;
    logic [DATA_W-1:0] out_u1;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        fill_level;
    logic [CNT_W-1:0]  drop_count;
    logic              overflow;
    logic              clear_stats;

    urng_pair_collector #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .out_u0      (out_u0),
        .out_u1      (out_u1),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fill_level  (fill_level),
        .drop_count  (drop_count),
        .overflow    (overflow),
        .clear_stats (clear_stats)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model state
    logic [63:0] exp_q[$];
    int          m_fill = 0;
    bit          m_have_u0 = 1'b0;
    logic [31:0] m_u0 = 32'd0;
    int          m_drop = 0;
    bit          m_ovf = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model of one clock edge, written from the behavioural rules.
    task automatic model_edge(input bit v, input logic [31:0] d, input bit rdy,
                              input bit clr, input bit rst);
        bit pop;
        bit drop;
        if (rst) begin
            exp_q.delete();
            m_fill    = 0;
            m_have_u0 = 1'b0;
            m_drop    = 0;
            m_ovf     = 1'b0;
        end else begin
            pop  = rdy && (m_fill > 0);
            drop = 1'b0;
            if (v) begin
                if (!m_have_u0) begin
                    if (d != 32'd0) begin
                        m_u0      = d;
                        m_have_u0 = 1'b1;
                    end
                end else begin
                    m_have_u0 = 1'b0;
                    if (m_fill < DEPTH || pop) begin
                        exp_q.push_back({m_u0, d});
                        m_fill++;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            if (pop) m_fill--;
            if (drop) begin
                m_drop = clr ? 2 : ((m_drop + 2 > CMAX) ? CMAX : m_drop + 2);
                m_ovf  = 1'b1;
            end else if (clr) begin
                m_drop = 0;
                m_ovf  = 1'b0;
            end
        end
    endtask

    task automatic step(input bit v, input logic [31:0] d, input bit rdy,
                        input bit clr, input bit rst);
        in_valid    = v;
        in_data     = d;
        out_ready   = rdy;
        clear_stats = clr;
        reset       = rst;
        @(posedge clock);
        model_edge(v, d, rdy, clr, rst);
        #1;
    endtask

    // Scoreboard monitor: status every cycle, pair data on each handshake.
    always @(negedge clock) begin
        logic [63:0] e;
        if (mon_en) begin
            chk("fill_level", 64'(fill_level), 64'(m_fill));
            chk("out_valid", 64'(out_valid), 64'(m_fill > 0));
            chk("drop_count", 64'(drop_count), 64'(m_drop));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pair", {out_u0, out_u1}, 64'd0);
                    errors++;
                    $display("FAIL pop_empty_scoreboard actual=1 expected=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("pair", {out_u0, out_u1}, e);
                    chk("u0_nonzero", 64'(out_u0 != 32'd0), 64'd1);
                end
            end
        end
    end

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (m_fill == 0) break;
            step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        end
        chk("drained", 64'(out_valid), 64'd0);
    endtask

    initial begin
        in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        clear_stats = 1'b0; reset = 1'b1;
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_fill", 64'(fill_level), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_u0", 64'(out_u0), 64'd0);
        chk("rst_u1", 64'(out_u1), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // Basic pair with one-cycle latency
        step(1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        chk("basic_not_yet", 64'(out_valid), 64'd0);
        step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        chk("basic_valid", 64'(out_valid), 64'd1);
        chk("basic_u0", 64'(out_u0), 64'h1);
        chk("basic_u1", 64'(out_u1), 64'h8000_0000);
        chk("basic_fill", 64'(fill_level), 64'd1);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("basic_pop_valid", 64'(out_valid), 64'd0);
        chk("basic_pop_fill", 64'(fill_level), 64'd0);

        // Zero rejection
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("zero_fill", 64'(fill_level), 64'd1);
        chk("zero_u0", 64'(out_u0), 64'h5);
        chk("zero_u1", 64'(out_u1), 64'h0);
        chk("zero_drop", 64'(drop_count), 64'd0);
        drain(8);

        // Overflow
        for (int i = 1; i <= 10; i++) step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        chk("ovf_fill", 64'(fill_level), 64'd4);
        chk("ovf_drop", 64'(drop_count), 64'd2);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_head", {out_u0, out_u1}, {32'd1, 32'd2});
        drain(8);

        // Full with concurrent pop
        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        chk("fullpop_fill0", 64'(fill_level), 64'd4);
        step(1'b1, 32'd11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'd12, 1'b1, 1'b0, 1'b0);
        chk("fullpop_fill", 64'(fill_level), 64'd4);
        chk("fullpop_drop", 64'(drop_count), 64'd2);
        chk("fullpop_head", {out_u0, out_u1}, {32'd3, 32'd4});
        drain(8);

        // Reset mid-pair
        step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        chk("rstmid_fill", 64'(fill_level), 64'd1);
        chk("rstmid_pair", {out_u0, out_u1}, {32'hB, 32'hC});
        chk("rstmid_drop", 64'(drop_count), 64'd0);
        drain(8);

        // Stats clear, clear-vs-drop priority, saturation
        for (int i = 1; i <= 10; i++) step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        chk("clr_pre_drop", 64'(drop_count), 64'd2);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("clr_drop", 64'(drop_count), 64'd0);
        chk("clr_ovf", 64'(overflow), 64'd0);
        step(1'b1, 32'd21, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'd22, 1'b0, 1'b1, 1'b0);
        chk("clrdrop_drop", 64'(drop_count), 64'd2);
        chk("clrdrop_ovf", 64'(overflow), 64'd1);
        for (int i = 0; i < 14; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b0, 1'b0);
        chk("sat_drop", 64'(drop_count), 64'(CMAX));
        drain(8);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit          v;
            bit          rdy;
            bit          clr;
            bit          rst;
            logic [31:0] d;
            v   = ($urandom_range(0, 3) != 0);
            d   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            rdy = (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 499) == 0);
            step(v, d, rdy, clr, rst);
        end
        drain(16);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
